// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32I pipeline.
// Selects ALU operands, computes the ALU result, resolves conditional
// branches back to fetch and registers the result into EX/MEM.
// Optional feature macro: EX_MUL_EN. When it is defined, an iterative
// shift-add multiplier runs MUL and stalls upstream through ex_busy. When it
// is undefined, MUL executes as its funct3 ALU op in one cycle.
module execute_stage #(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_re_in,
    input  logic            mem_we_in,
    input  logic            reg_file_write_in,
    input  logic            branch_instruction,
    input  logic [1:0]      alu_op,
    input  logic [1:0]      select_mux_1,
    input  logic [1:0]      select_mux_2,
    input  logic [1:0]      select_mux_4,
    input  logic [XLEN-1:0] reg_a,
    input  logic [XLEN-1:0] reg_b,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      addr_rd,
    input  logic [6:0]      funct7e3,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            ex_busy,
    output logic            mem_re_out,
    output logic            mem_we_out,
    output logic            reg_file_write_out,
    output logic [1:0]      select_mux_4_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_ex_mem
);

    localparam int SHW = $clog2(XLEN);

    // One EX/MEM pipeline entry.
    typedef struct packed {
        logic            mem_re;
        logic            mem_we;
        logic            rf_we;
        logic [1:0]      wb_sel;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store;
        logic [4:0]      rd;
    } exmem_t;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_out;
    logic [SHW-1:0]  shamt;
    logic [2:0]      funct3;
    logic            is_sub;
    logic            is_sra;
    logic            cond;
    exmem_t          entry_now;
    exmem_t          exmem_d;
    exmem_t          exmem_q;
    logic            unused_funct_bits;

    assign funct3 = funct7e3[2:0];
    assign is_sra = funct7e3[6];
    // Subtract only for R-type; I-type addi with funct7e3[6] set stays an add.
    assign is_sub = funct7e3[6] && (select_mux_2 == 2'b00);
    assign unused_funct_bits = ^funct7e3[5:3];

    // Operand muxes and the ALU proper.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alu_a   = '0;
        alu_b   = immediate;
        alu_out = '0;
        case (select_mux_1)
            2'b00:   alu_a = reg_a;
            2'b01:   alu_a = pc;
            default: alu_a = '0;
        endcase
        case (select_mux_2)
            2'b00:   alu_b = reg_b;
            2'b10:   alu_b = XLEN'(4);
            default: alu_b = immediate;
        endcase
        shamt = alu_b[SHW-1:0];
        case (alu_op)
            2'b01: alu_out = alu_a - alu_b;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_out = is_sub ? (alu_a - alu_b) : (alu_a + alu_b);
                    3'b001:  alu_out = alu_a << shamt;
                    3'b010:  alu_out = XLEN'($signed(alu_a) < $signed(alu_b));
                    3'b011:  alu_out = XLEN'(alu_a < alu_b);
                    3'b100:  alu_out = alu_a ^ alu_b;
                    3'b101:  alu_out = is_sra ? XLEN'($signed(alu_a) >>> shamt)
                                              : (alu_a >> shamt);
                    3'b110:  alu_out = alu_a | alu_b;
                    default: alu_out = alu_a & alu_b;
                endcase
            end
            default: alu_out = alu_a + alu_b;
        endcase
    end

    // Branch resolution: compares the two register operands, target is pc + immediate.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (reg_a == reg_b);
            3'b001:  cond = (reg_a != reg_b);
            3'b100:  cond = ($signed(reg_a) < $signed(reg_b));
            3'b101:  cond = ($signed(reg_a) >= $signed(reg_b));
            3'b110:  cond = (reg_a < reg_b);
            3'b111:  cond = (reg_a >= reg_b);
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken  = (alu_op == 2'b01) && branch_instruction && cond;
    assign branch_target = pc + immediate;

    // EX/MEM entry for the instruction currently in ID/EX.
    always_comb begin
        entry_now.mem_re = mem_re_in;
        entry_now.mem_we = mem_we_in;
        entry_now.rf_we  = reg_file_write_in;
        entry_now.wb_sel = select_mux_4;
        entry_now.result = alu_out;
        entry_now.store  = reg_b;
        entry_now.rd     = addr_rd;
    end

`ifdef EX_MUL_EN
    localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    mul_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0] prod_next;
    exmem_t          mul_ctl_q, mul_ctl_d;
    logic            is_mul;

    assign is_mul    = (alu_op == 2'b10) && funct7e3[5];
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign ex_busy   = (state_q == S_BUSY);

    // Multiplier FSM next state and EX/MEM entry selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        mul_ctl_d = mul_ctl_q;
        exmem_d   = entry_now;
        case (state_q)
            S_BUSY: begin
                prod_d   = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                exmem_d  = '0;
                if (cnt_q == CW'(MUL_STEPS - 1)) begin
                    state_d        = S_DONE;
                    exmem_d        = mul_ctl_q;
                    exmem_d.result = prod_next;
                end
            end
            default: begin
                // IDLE and DONE both accept the instruction waiting in ID/EX.
                if (is_mul) begin
                    state_d   = S_BUSY;
                    cnt_d     = '0;
                    mcand_d   = alu_a;
                    mplier_d  = alu_b;
                    prod_d    = '0;
                    mul_ctl_d = entry_now;
                    exmem_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Multiplier state and operand registers; reset aborts any multiply in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            mul_ctl_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            mul_ctl_q <= mul_ctl_d;
        end
    end
`else
    assign ex_busy = 1'b0;

    // Without the multiplier every instruction goes straight into EX/MEM.
    always_comb begin
        exmem_d = entry_now;
    end
`endif

    // EX/MEM pipeline register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so all registers update from pre-edge values.
            exmem_q <= exmem_d;
        end
    end

    assign mem_re_out         = exmem_q.mem_re;
    assign mem_we_out         = exmem_q.mem_we;
    assign reg_file_write_out = exmem_q.rf_we;
    assign select_mux_4_out   = exmem_q.wb_sel;
    assign alu_result         = exmem_q.result;
    assign store_data         = exmem_q.store;
    assign rd_ex_mem          = exmem_q.rd;

endmodule
